// File: rtl/pipelined_adder.sv
// Pipelined N-bit add/subtract unit with valid/ready handshake.
// The carry chain is cut into STAGES segments of SEG bits. Each stage adds
// one segment using the carry registered by the previous stage. Operand
// bits not yet consumed ride along in shrinking skew registers, and result
// segments already produced ride along in growing deskew registers. The
// final stage's registers are the output registers.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SEG = WIDTH / STAGES;

  // Whole pipe moves together; a stalled output freezes every stage.
  logic             adv;
  logic [WIDTH-1:0] beff;
  logic             ceff;

  assign beff     = sub ? ~b : b;
  assign ceff     = sub ? 1'b1 : cin;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : gen_stage
      logic                  v_in;
      logic                  c_in;
      logic [SEG-1:0]        seg_a;
      logic [SEG-1:0]        seg_b;
      logic [SEG:0]          seg_sum;
      logic [(gi+1)*SEG-1:0] res_next;
      logic                  v_reg;
      logic                  c_reg;
      logic [(gi+1)*SEG-1:0] res_reg;

      // Stage 0 takes its segment straight from the ports; later stages
      // take the lowest bits of the previous stage's skew registers.
      if (gi == 0) begin : g_src
        assign v_in     = in_valid;
        assign c_in     = ceff;
        assign seg_a    = a[SEG-1:0];
        assign seg_b    = beff[SEG-1:0];
        assign res_next = seg_sum[SEG-1:0];
      end else begin : g_src
        assign v_in     = gen_stage[gi-1].v_reg;
        assign c_in     = gen_stage[gi-1].c_reg;
        assign seg_a    = gen_stage[gi-1].g_skew.opa_reg[SEG-1:0];
        assign seg_b    = gen_stage[gi-1].g_skew.opb_reg[SEG-1:0];
        assign res_next = {seg_sum[SEG-1:0], gen_stage[gi-1].res_reg};
      end

      assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, c_in};

      // Valid advances with the pipe; data only loads when a real beat
      // arrives, so the output keeps the last result across bubbles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg   <= 1'b0;
          c_reg   <= 1'b0;
          res_reg <= '0;
        end else if (adv) begin
          v_reg <= v_in;
          if (v_in) begin
            c_reg   <= seg_sum[SEG];
            res_reg <= res_next;
          end
        end
      end

      if (gi < STAGES - 1) begin : g_skew
        localparam int UW = WIDTH - (gi + 1) * SEG;
        logic [UW-1:0] opa_reg;
        logic [UW-1:0] opb_reg;
        logic [UW-1:0] opa_next;
        logic [UW-1:0] opb_next;

        if (gi == 0) begin : g_from_port
          assign opa_next = a[WIDTH-1:SEG];
          assign opb_next = beff[WIDTH-1:SEG];
        end else begin : g_from_prev
          assign opa_next = gen_stage[gi-1].g_skew.opa_reg[UW+SEG-1:SEG];
          assign opb_next = gen_stage[gi-1].g_skew.opb_reg[UW+SEG-1:SEG];
        end

        // Unconsumed upper operand bits travel with their beat.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            opa_reg <= '0;
            opb_reg <= '0;
          end else if (adv && v_in) begin
            opa_reg <= opa_next;
            opb_reg <= opb_next;
          end
        end
      end else begin : g_last
        logic ovf_reg;

        // Signed overflow: operands share a sign that the result does not,
        // equivalent to carry-in XOR carry-out at the MSB.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_reg <= 1'b0;
          end else if (adv && v_in) begin
            ovf_reg <= (seg_a[SEG-1] == seg_b[SEG-1]) &&
                       (seg_sum[SEG-1] != seg_a[SEG-1]);
          end
        end
      end
    end
  endgenerate

  assign out_valid = gen_stage[STAGES-1].v_reg;
  assign sum       = gen_stage[STAGES-1].res_reg;
  assign cout      = gen_stage[STAGES-1].c_reg;
  assign overflow  = gen_stage[STAGES-1].g_last.ovf_reg;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed testbench for pipelined_adder: main instance with STAGES=4,
// plus STAGES=1 and STAGES=16 instances sharing the same stimulus.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;

  logic        in_ready,  out_valid,  cout,  overflow;
  logic [15:0] sum;
  logic        in_ready_s1,  out_valid_s1,  cout_s1,  overflow_s1;
  logic [15:0] sum_s1;
  logic        in_ready_s16, out_valid_s16, cout_s16, overflow_s16;
  logic [15:0] sum_s16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s1),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_s1),
    .out_ready(out_ready), .sum(sum_s1), .cout(cout_s1), .overflow(overflow_s1)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(16)) dut_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s16),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_s16),
    .out_ready(out_ready), .sum(sum_s16), .cout(cout_s16), .overflow(overflow_s16)
  );

  // Present one beat for one cycle; returns 1 ns after the accepting edge.
  task automatic drive_beat(input logic [15:0] va, input logic [15:0] vb,
                            input logic vc, input logic vs);
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count cycles from the drive cycle until out_valid, bounded.
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 24) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #6;
    total++;
    if ({out_valid, cout, overflow, sum} !== 19'h0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b c=%b o=%b s=%h, want all 0", out_valid, cout, overflow, sum);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    total++;
    if ({out_valid_s1, sum_s1, out_valid_s16, sum_s16} !== 34'h0) begin
      bad++;
      $display("FAIL reset_small_large: got v1=%b s1=%h v16=%b s16=%h want 0", out_valid_s1, sum_s1, out_valid_s16, sum_s16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_add();
    int n;
    drive_beat(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_out(n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL add_latency: got %0d want 4", n); end
    total++;
    if ({cout, overflow, sum} !== {1'b0, 1'b0, 16'h2345}) begin
      bad++; $display("FAIL add_basic: got c=%b o=%b s=%h want c=0 o=0 s=2345", cout, overflow, sum);
    end
    @(posedge clk); #1;
    drive_beat(16'h00FF, 16'h0000, 1'b1, 1'b0);
    wait_out(n);
    total++;
    if ({cout, overflow, sum} !== {1'b0, 1'b0, 16'h0100} || n !== 4) begin
      bad++; $display("FAIL add_cin: got c=%b o=%b s=%h lat=%0d want s=0100 lat=4", cout, overflow, sum, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_carry();
    int n;
    drive_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_out(n);
    total++;
    if ({cout, overflow, sum} !== {1'b1, 1'b0, 16'h0000} || n !== 4) begin
      bad++; $display("FAIL carry_wrap: got c=%b o=%b s=%h lat=%0d want c=1 o=0 s=0000", cout, overflow, sum, n);
    end
    @(posedge clk); #1;
    drive_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_out(n);
    total++;
    if ({cout, overflow, sum} !== {1'b0, 1'b1, 16'h8000} || n !== 4) begin
      bad++; $display("FAIL carry_ovf: got c=%b o=%b s=%h lat=%0d want c=0 o=1 s=8000", cout, overflow, sum, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    int n;
    drive_beat(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_out(n);
    total++;
    if ({cout, overflow, sum} !== {1'b0, 1'b0, 16'hFFFE} || n !== 4) begin
      bad++; $display("FAIL sub_borrow: got c=%b o=%b s=%h lat=%0d want c=0 o=0 s=FFFE", cout, overflow, sum, n);
    end
    @(posedge clk); #1;
    drive_beat(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_out(n);
    total++;
    if ({cout, overflow, sum} !== {1'b1, 1'b1, 16'h7FFF} || n !== 4) begin
      bad++; $display("FAIL sub_ovf: got c=%b o=%b s=%h lat=%0d want c=1 o=1 s=7FFF", cout, overflow, sum, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic        vs [8];
    logic [17:0] ve [8];
    va = '{16'h0001, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'h4000, 16'h1000, 16'h0000, 16'h7FFF};
    vb = '{16'h0002, 16'h0001, 16'h0001, 16'hFFFF, 16'h4000, 16'h0001, 16'h0001, 16'hFFFF};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    // {cout, overflow, sum}
    ve = '{18'h00003, 18'h00100, 18'h01001, 18'h2FFFE,
           18'h18000, 18'h20FFF, 18'h0FFFF, 18'h18000};
    for (int t = 0; t < 13; t++) begin
      if (t < 8) begin
        a = va[t]; b = vb[t]; cin = vc[t]; sub = vs[t]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      total++;
      if (t >= 4 && t < 12) begin
        if (out_valid !== 1'b1 || {cout, overflow, sum} !== ve[t-4]) begin
          bad++;
          $display("FAIL stream_beat%0d: got v=%b c=%b o=%b s=%h want v=1 {c,o,s}=%h", t-4, out_valid, cout, overflow, sum, ve[t-4]);
        end
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL stream_idle_cycle%0d: got out_valid=%b want 0", t, out_valid);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] va [5];
    logic [15:0] vb [5];
    logic [15:0] ve [5];
    va = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    vb = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    ve = '{16'h1112, 16'h2224, 16'h3336, 16'h4448, 16'h555A};
    cin = 1'b0; sub = 1'b0;
    for (int t = 0; t < 4; t++) begin
      a = va[t]; b = vb[t]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    // Pipe full, first result at the output: stall it.
    a = va[4]; b = vb[4]; in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || sum !== ve[0] || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_stall_start: got v=%b s=%h rdy=%b want v=1 s=%h rdy=0", out_valid, sum, in_ready, ve[0]);
    end
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || {cout, overflow, sum} !== {2'b00, ve[0]} || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b c=%b o=%b s=%h rdy=%b want v=1 s=%h rdy=0", t, out_valid, cout, overflow, sum, in_ready, ve[0]);
      end
    end
    out_ready = 1'b1;
    for (int t = 1; t < 6; t++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if (t < 5) begin
        if (out_valid !== 1'b1 || sum !== ve[t]) begin
          bad++;
          $display("FAIL bp_resume%0d: got v=%b s=%h want v=1 s=%h", t, out_valid, sum, ve[t]);
        end
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL bp_drain: got out_valid=%b want 0", out_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    int lat4, lat1, lat16;
    logic [15:0] s4, s1, s16;
    cin = 1'b0; sub = 1'b0;
    for (int t = 0; t < 3; t++) begin
      a = 16'h0101 * 16'(t + 1); b = 16'h0010; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, cout, overflow, sum} !== 19'h0) begin
      bad++;
      $display("FAIL rst_mid_main: got v=%b c=%b o=%b s=%h want all 0", out_valid, cout, overflow, sum);
    end
    total++;
    if ({out_valid_s1, sum_s1} !== 17'h0) begin
      bad++;
      $display("FAIL rst_mid_s1: got v=%b s=%h want 0", out_valid_s1, sum_s1);
    end
    total++;
    if ({out_valid_s16, sum_s16} !== 17'h0) begin
      bad++;
      $display("FAIL rst_mid_s16: got v=%b s=%h want 0", out_valid_s16, sum_s16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int t = 0; t < 24; t++) begin
      @(posedge clk); #1;
      if (out_valid || out_valid_s1 || out_valid_s16) stale++;
    end
    total++;
    if (stale !== 0) begin
      bad++;
      $display("FAIL rst_stale_beats: got %0d valid cycles want 0", stale);
    end
    // Fresh beat whose carry ripples through every segment.
    a = 16'h0F0F; b = 16'h00F1; in_valid = 1'b1;
    lat4 = 0; lat1 = 0; lat16 = 0;
    s4 = '0; s1 = '0; s16 = '0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid && lat4 == 0)     begin lat4 = c;  s4 = sum;      end
      if (out_valid_s1 && lat1 == 0)  begin lat1 = c;  s1 = sum_s1;   end
      if (out_valid_s16 && lat16 == 0) begin lat16 = c; s16 = sum_s16; end
    end
    total++;
    if (lat4 !== 4 || s4 !== 16'h1000) begin
      bad++; $display("FAIL rst_after_main: got lat=%0d s=%h want lat=4 s=1000", lat4, s4);
    end
    total++;
    if (lat1 !== 1 || s1 !== 16'h1000) begin
      bad++; $display("FAIL rst_after_s1: got lat=%0d s=%h want lat=1 s=1000", lat1, s1);
    end
    total++;
    if (lat16 !== 16 || s16 !== 16'h1000) begin
      bad++; $display("FAIL rst_after_s16: got lat=%0d s=%h want lat=16 s=1000", lat16, s16);
    end
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2 rst_n = 1'b0;
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined N-bit add/subtract unit. It is the clocked successor to the team's combinational ripple-carry adder.
- The carry chain is split into STAGES equal segments. Each segment is registered, and the carry is forwarded stage to stage, so long adders close timing at the core clock.
- Uses a valid/ready handshake on both input and output, with backpressure. It sits between operand-issue logic and the result writeback in datapath blocks.

Parameters:
- WIDTH, 16, operand and result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages; 1 <= STAGES <= WIDTH. Segment width SEG = WIDTH/STAGES.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept an operand beat this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used in add mode only.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB. In subtract mode, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst_n is asynchronous and active-low. While rst_n=0, all stage valid bits, out_valid, sum, cout and overflow are 0. in_ready is 1 after reset.
- Operation: effective B is b when sub=0 and ~b when sub=1. Effective carry-in is cin when sub=0 and 1 when sub=1; cin is ignored when sub=1. Result = A + Beff + Ceff, modulo 2^WIDTH.
- Stage structure:
  - Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] using the carry registered by stage k-1. Stage 0 uses Ceff.
  - Upper operand segments not yet consumed travel with the beat (skew registers).
  - Lower result segments already produced also travel with the beat (deskew registers).
- Latency: exactly STAGES cycles from input handshake to out_valid, with no stalls. With STAGES=1 the result is registered once.
- Throughput: one beat per cycle when out_ready is held at 1.
- Handshake:
  - Global advance enable: adv = out_ready | ~out_valid.
  - in_ready = adv, combinational from out_ready and out_valid only; no dependency on in_valid.
  - An input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
  - When adv=0, every stage register, including data, holds its value. sum/cout/overflow stay stable while out_valid=1 and out_ready=0.
  - When adv=1, every stage shifts forward one position. Stage 0 valid <= in_valid.
  - Bubbles are not collapsed: they occupy a stage slot and advance only with adv.
- Outputs:
  - cout = carry out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB, computed in the final stage.
  - Output data registers are updated only when a valid beat moves into the final stage. Data is don't-care-free: it retains the last valid result when out_valid=0.
- Boundary conditions:
  - All-ones + 1: sum wraps to 0, cout=1.
  - A carry generated in segment 0 propagates through all segments via the stage carries (full ripple across stages). The result must match the single-cycle sum exactly.
  - Simultaneous input and output transfer in the same cycle is a normal advance; no beat is lost or duplicated.
  - Reset mid-operation discards all in-flight beats. The first out_valid after reset release comes from a beat accepted after release.
- Inputs a/b/cin/sub are sampled only on an input transfer. Values at other times have no effect.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1: a=0x1234, b=0x1111, sub=0, cin=0 → after 4 cycles sum=0x2345, cout=0, overflow=0.
- Carry across all stages: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Also a=0x7FFF, b=0x0001 → sum=0x8000, overflow=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, overflow=0. Also a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, overflow=1.
- Streaming 8 back-to-back random beats with out_ready=1 → 8 consecutive out_valid cycles starting at cycle 4, each result matching the reference model, in order.
- Backpressure: out_ready=0 for 3 cycles while the pipe is full → in_ready=0, outputs stable. Release → results resume in order with no loss or duplication.
- Reset: assert rst_n=0 asynchronously with 3 beats in flight → out_valid=0 and sum=0 immediately. After release, no stale beat appears. Repeat with STAGES=1 and STAGES=16 (SEG=1).
